// File: rtl/paint_brush_ctrl.sv
// Paint-canvas sequencer: square brush with edge clipping, eraser mode, and
// palette/cursor overlay hand-off. Brush pixels leave through a valid/ready write port.
module paint_brush_ctrl #(
  parameter int unsigned         COORD_W   = 8,
  parameter int unsigned         COLOR_W   = 8,
  parameter int unsigned         CANVAS_W  = 64,
  parameter int unsigned         CANVAS_H  = 64,
  parameter int unsigned         MAX_BRUSH = 4,
  parameter logic [COLOR_W-1:0]  BG_COLOR  = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             init,
  input  logic [COORD_W-1:0]               cur_x,
  input  logic [COORD_W-1:0]               cur_y,
  input  logic [COORD_W-1:0]               pal_x,
  input  logic [COORD_W-1:0]               pal_y,
  input  logic                             key_c,
  input  logic                             key_enter,
  input  logic                             key_size,
  input  logic                             key_erase,
  input  logic                             key_pal_sel,
  input  logic                             cursor_done,
  input  logic                             palette_done,
  input  logic                             wr_ready,
  output logic                             wr_valid,
  output logic [COORD_W-1:0]               wr_x,
  output logic [COORD_W-1:0]               wr_y,
  output logic [COLOR_W-1:0]               wr_data,
  output logic                             cursor_start,
  output logic                             palette_start,
  output logic [COLOR_W-1:0]               color,
  output logic [$clog2(MAX_BRUSH+1)-1:0]   brush_size,
  output logic                             eraser,
  output logic                             busy
);

  localparam int unsigned BW   = $clog2(MAX_BRUSH + 1);
  localparam int unsigned XW   = COORD_W + 1;
  localparam int unsigned HALF = COLOR_W / 2;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    DECODE,
    PAINT,
    CURSOR,
    PALETTE,
    PAL_CHK,
    SET_COLOR
  } state_t;

  state_t              state;
  logic [COORD_W-1:0]  ax;
  logic [COORD_W-1:0]  ay;
  logic [BW-1:0]       ox;
  logic [BW-1:0]       oy;

  logic [XW-1:0]       ax_ext;
  logic [XW-1:0]       ay_ext;
  logic [XW-1:0]       rem_x;
  logic [XW-1:0]       rem_y;
  logic [BW-1:0]       nx;
  logic [BW-1:0]       ny;
  logic [BW-1:0]       ox_nxt;
  logic [BW-1:0]       oy_nxt;
  logic [XW-1:0]       px_nxt;
  logic [XW-1:0]       py_nxt;
  logic                last_px;
  logic                all_clipped;
  logic [COLOR_W-1:0]  pix_color;
  logic                unused_pal;

  assign unused_pal = ^{pal_x[COORD_W-1:HALF], pal_y[COORD_W-1:HALF]};

  // Clipping reduces the brush to an nx-by-ny rectangle of on-canvas pixels,
  // so skipped pixels never cost a cycle and never reach the write port.
  always_comb begin
    ax_ext      = {1'b0, ax};
    ay_ext      = {1'b0, ay};
    rem_x       = (ax_ext < XW'(CANVAS_W)) ? XW'(CANVAS_W) - ax_ext : '0;
    rem_y       = (ay_ext < XW'(CANVAS_H)) ? XW'(CANVAS_H) - ay_ext : '0;
    nx          = (rem_x < XW'(brush_size)) ? BW'(rem_x) : brush_size;
    ny          = (rem_y < XW'(brush_size)) ? BW'(rem_y) : brush_size;
    all_clipped = (nx == '0) || (ny == '0);
    last_px     = (ox == nx - BW'(1)) && (oy == ny - BW'(1));
    if (ox + BW'(1) < nx) begin
      ox_nxt = ox + BW'(1);
      oy_nxt = oy;
    end else begin
      ox_nxt = '0;
      oy_nxt = oy + BW'(1);
    end
    px_nxt    = ax_ext + XW'(ox_nxt);
    py_nxt    = ay_ext + XW'(oy_nxt);
    pix_color = eraser ? BG_COLOR : color;
  end

  // Sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ax            <= '0;
      ay            <= '0;
      ox            <= '0;
      oy            <= '0;
      wr_valid      <= 1'b0;
      wr_x          <= '0;
      wr_y          <= '0;
      wr_data       <= BG_COLOR;
      cursor_start  <= 1'b0;
      palette_start <= 1'b0;
      color         <= BG_COLOR;
      brush_size    <= BW'(1);
      eraser        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init) begin
            state <= LATCH;
            busy  <= 1'b1;
          end
        end
        LATCH: begin
          ax    <= cur_x;
          ay    <= cur_y;
          state <= DECODE;
        end
        DECODE: begin
          if (key_c) begin
            state         <= PALETTE;
            palette_start <= 1'b1;
          end else if (key_enter) begin
            state <= PAINT;
            ox    <= '0;
            oy    <= '0;
          end else if (key_size) begin
            brush_size <= (brush_size == BW'(MAX_BRUSH)) ? BW'(1) : brush_size + BW'(1);
            state      <= LATCH;
          end else if (key_erase) begin
            eraser <= ~eraser;
            state  <= LATCH;
          end else begin
            state        <= CURSOR;
            cursor_start <= 1'b1;
          end
        end
        PAINT: begin
          // First PAINT cycle presents the anchor pixel; later cycles advance on handshake.
          if (!wr_valid) begin
            if (all_clipped) begin
              state <= LATCH;
            end else begin
              wr_valid <= 1'b1;
              wr_x     <= ax;
              wr_y     <= ay;
              wr_data  <= pix_color;
            end
          end else if (wr_ready) begin
            if (last_px) begin
              wr_valid <= 1'b0;
              state    <= LATCH;
            end else begin
              ox   <= ox_nxt;
              oy   <= oy_nxt;
              wr_x <= COORD_W'(px_nxt);
              wr_y <= COORD_W'(py_nxt);
            end
          end
        end
        CURSOR: begin
          if (cursor_done) begin
            cursor_start <= 1'b0;
            state        <= LATCH;
          end
        end
        PALETTE: begin
          if (palette_done) begin
            palette_start <= 1'b0;
            state         <= PAL_CHK;
          end
        end
        PAL_CHK: begin
          if (key_pal_sel) begin
            state <= SET_COLOR;
          end else begin
            state         <= PALETTE;
            palette_start <= 1'b1;
          end
        end
        SET_COLOR: begin
          color  <= {pal_x[HALF-1:0], pal_y[HALF-1:0]};
          eraser <= 1'b0;
          state  <= LATCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_paint_brush_ctrl.sv
// Directed bench for paint_brush_ctrl: a brush/colour model predicts the pixel
// stream, a monitor checks every handshake and hold cycle against it.
module tb_paint_brush_ctrl;

  localparam int unsigned COORD_W   = 8;
  localparam int unsigned COLOR_W   = 8;
  localparam int unsigned CANVAS_W  = 64;
  localparam int unsigned CANVAS_H  = 64;
  localparam int unsigned MAX_BRUSH = 4;
  localparam logic [7:0]  BG        = 8'h00;
  localparam int unsigned BW        = $clog2(MAX_BRUSH + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               init = 1'b0;
  logic [COORD_W-1:0] cur_x = '0, cur_y = '0, pal_x = '0, pal_y = '0;
  logic               key_c = 1'b0, key_enter = 1'b0, key_size = 1'b0, key_erase = 1'b0;
  logic               key_pal_sel = 1'b0, cursor_done = 1'b0, palette_done = 1'b0;
  logic               wr_ready;
  logic               wr_valid;
  logic [COORD_W-1:0] wr_x, wr_y;
  logic [COLOR_W-1:0] wr_data;
  logic               cursor_start, palette_start;
  logic [COLOR_W-1:0] color;
  logic [BW-1:0]      brush_size;
  logic               eraser, busy;

  paint_brush_ctrl dut (
    .clk(clk), .rst_n(rst_n), .init(init),
    .cur_x(cur_x), .cur_y(cur_y), .pal_x(pal_x), .pal_y(pal_y),
    .key_c(key_c), .key_enter(key_enter), .key_size(key_size), .key_erase(key_erase),
    .key_pal_sel(key_pal_sel), .cursor_done(cursor_done), .palette_done(palette_done),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .cursor_start(cursor_start), .palette_start(palette_start), .color(color),
    .brush_size(brush_size), .eraser(eraser), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         stall_left = 0;
  logic [7:0] m_color = BG;
  int         m_size = 1;
  logic       m_eraser = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every brush offset, kept only if it lands on the canvas, in raster order.
  task automatic push_brush(input logic [7:0] x, input logic [7:0] y);
    for (int oy = 0; oy < m_size; oy++) begin
      for (int ox = 0; ox < m_size; ox++) begin
        wr_t e;
        e.x = int'(x) + ox;
        e.y = int'(y) + oy;
        e.d = m_eraser ? BG : m_color;
        if (e.x < int'(CANVAS_W) && e.y < int'(CANVAS_H)) exp_q.push_back(e);
      end
    end
  endtask

  // Ready driver: holds wr_ready low for stall_left cycles of an offered write.
  initial begin : rdy_drv
    wr_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_left > 0 && wr_valid) begin
        wr_ready = 1'b0;
        stall_left--;
      end else begin
        wr_ready = 1'b1;
      end
    end
  end

  // Monitor: handshakes against the model queue, stability while stalled, bounds.
  initial begin : mon
    logic       pv;
    logic [7:0] px, py, pd;
    wr_t        e;
    pv = 1'b0; px = '0; py = '0; pd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          check("hold_valid", wr_valid, 1);
          check("hold_x", wr_x, px);
          check("hold_y", wr_y, py);
          check("hold_data", wr_data, pd);
        end
        if (wr_valid) begin
          check("x_on_canvas", wr_x < 8'(CANVAS_W), 1);
          check("y_on_canvas", wr_y < 8'(CANVAS_H), 1);
        end
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got (%0d,%0d,0x%0h) expected none", wr_x, wr_y, wr_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_x", wr_x, e.x);
            check("wr_y", wr_y, e.y);
            check("wr_data", wr_data, e.d);
          end
        end
        pv = wr_valid && !wr_ready;
        px = wr_x; py = wr_y; pd = wr_data;
      end
    end
  end

  // From the parked CURSOR state: release the cursor and present keys through DECODE.
  task automatic do_keys(input logic c, input logic enter, input logic size, input logic erase,
                         input logic [7:0] x, input logic [7:0] y);
    cur_x = x; cur_y = y;
    key_c = c; key_enter = enter; key_size = size; key_erase = erase;
    cursor_done = 1'b1;
    @(negedge clk);
    cursor_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    key_c = 1'b0; key_enter = 1'b0; key_size = 1'b0; key_erase = 1'b0;
  endtask

  task automatic wait_park(input string name);
    int n = 0;
    while (cursor_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, cursor_start, 1);
  endtask

  task automatic do_size();
    do_keys(1'b0, 1'b0, 1'b1, 1'b0, cur_x, cur_y);
    m_size = (m_size == int'(MAX_BRUSH)) ? 1 : m_size + 1;
    wait_park("park_size");
    check("brush_size", brush_size, m_size);
  endtask

  task automatic do_erase();
    do_keys(1'b0, 1'b0, 1'b0, 1'b1, cur_x, cur_y);
    m_eraser = ~m_eraser;
    wait_park("park_erase");
    check("eraser", eraser, m_eraser);
  endtask

  task automatic do_paint(input logic [7:0] x, input logic [7:0] y, input int exp_n);
    push_brush(x, y);
    check("model_pixel_count", exp_q.size(), exp_n);
    do_keys(1'b0, 1'b1, 1'b0, 1'b0, x, y);
    cur_x = ~x;
    cur_y = ~y;
    wait_park("park_paint");
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_palette(input logic with_enter, input logic reloop,
                            input logic [7:0] px, input logic [7:0] py);
    int n = 0;
    do_keys(1'b1, with_enter, 1'b0, 1'b0, cur_x, cur_y);
    while (palette_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("palette_start", palette_start, 1);
    if (reloop) begin
      palette_done = 1'b1;
      @(negedge clk);
      palette_done = 1'b0;
      check("palchk_drop", palette_start, 0);
      @(negedge clk);
      check("palchk_reloop", palette_start, 1);
    end
    pal_x = px; pal_y = py;
    key_pal_sel = 1'b1;
    palette_done = 1'b1;
    @(negedge clk);
    palette_done = 1'b0;
    @(negedge clk);
    key_pal_sel = 1'b0;
    m_color = {px[3:0], py[3:0]};
    m_eraser = 1'b0;
    wait_park("park_palette");
    check("color", color, m_color);
    check("eraser_after_pal", eraser, 0);
  endtask

  initial begin : watchdog
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    repeat (3) @(negedge clk);
    check("rst_valid", wr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_size", brush_size, 1);
    check("rst_color", color, BG);
    check("rst_data", wr_data, BG);
    check("rst_cursor", cursor_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_init_busy", busy, 0);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("busy_after_init", busy, 1);
    wait_park("park_start");

    // Single pixel, first write one cycle after PAINT entry.
    push_brush(8'd10, 8'd20);
    check("t1_model_count", exp_q.size(), 1);
    do_keys(1'b0, 1'b1, 1'b0, 1'b0, 8'd10, 8'd20);
    check("t1_valid_at_entry", wr_valid, 0);
    @(negedge clk);
    check("t1_valid_next", wr_valid, 1);
    check("t1_x", wr_x, 10);
    check("t1_y", wr_y, 20);
    check("t1_data", wr_data, 8'h00);
    wait_park("park_t1");
    check("t1_drained", exp_q.size(), 0);

    // Colour 5A, size 3, clipped at bottom-right corner.
    do_palette(1'b0, 1'b0, 8'h05, 8'h0A);
    check("t2_color_lit", color, 8'h5A);
    do_size();
    do_size();
    check("t2_size_lit", brush_size, 3);
    do_paint(8'd62, 8'd63, 2);

    // Size wrap 4 -> 1, then size 2 with a stalled first pixel.
    do_size();
    check("size4_lit", brush_size, 4);
    do_size();
    check("wrap_lit", brush_size, 1);
    do_size();
    stall_left = 3;
    push_brush(8'd0, 8'd0);
    check("t3_count", exp_q.size(), 4);
    check("t3_third_y", exp_q[2].y, 1);
    check("t3_third_x", exp_q[2].x, 0);
    do_keys(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    cur_x = 8'd40;
    wait_park("park_t3");
    check("t3_drained", exp_q.size(), 0);

    // Eraser: fully clipped anchor, x-edge clip, and erased pixels.
    do_erase();
    check("eraser_lit", eraser, 1);
    do_paint(8'd255, 8'd10, 0);
    do_paint(8'd63, 8'd0, 2);
    do_paint(8'd5, 8'd5, 4);

    // Palette selection clears eraser.
    do_palette(1'b0, 1'b0, 8'd3, 8'd7);
    check("t4_color_lit", color, 8'h37);
    check("t4_eraser_lit", eraser, 0);

    // key_c beats key_enter; PAL_CHK without select loops back.
    do_palette(1'b1, 1'b1, 8'd1, 8'd2);
    check("t5_color_lit", color, 8'h12);
    check("t5_no_write", exp_q.size(), 0);

    // init is ignored while running.
    init = 1'b1;
    repeat (3) @(negedge clk);
    init = 1'b0;
    check("init_ignored", cursor_start, 1);
    check("init_busy", busy, 1);

    // Reset mid-brush with a write outstanding.
    stall_left = 1000;
    do_keys(1'b0, 1'b1, 1'b0, 1'b0, 8'd30, 8'd30);
    begin
      int n = 0;
      while (wr_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("t6_valid_before", wr_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_valid", wr_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_x", wr_x, 0);
    check("t6_y", wr_y, 0);
    check("t6_data", wr_data, BG);
    check("t6_color", color, BG);
    check("t6_size", brush_size, 1);
    check("t6_eraser", eraser, 0);
    check("t6_cursor", cursor_start, 0);
    check("t6_palette", palette_start, 0);
    stall_left = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_no_resume_valid", wr_valid, 0);
    check("t6_no_resume_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
